// File: rtl/pipelined_cla_adder_if.sv
// ============================================================================
// pipelined_cla_adder_if
// Valid/ready operand and result bundle for pipelined_cla_adder.
// Optional ovf signal present when PIPELINED_CLA_ADDER_OVF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// pipelined_cla_adder
// Two-stage carry-lookahead add/subtract with valid/ready flow control.
// Optional signed overflow output: define PIPELINED_CLA_ADDER_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int c_NGRP = WIDTH / GROUP;

    logic                r_s1_valid;
    logic [WIDTH-1:0]    r_p;
    logic [WIDTH-1:0]    r_g;
    logic [c_NGRP-1:0]   r_gp;
    logic [c_NGRP-1:0]   r_gg;
    logic                r_c0;
    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_s;
    logic                r_cout;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    logic                r_ovf;
`endif

    logic                w_s1_load;
    logic                w_s2_load;
    logic [WIDTH-1:0]    w_b_eff;
    logic [WIDTH-1:0]    w_p;
    logic [WIDTH-1:0]    w_g;
    logic                w_c0;
    logic [c_NGRP-1:0]   w_gp;
    logic [c_NGRP-1:0]   w_gg;
    logic [c_NGRP:0]     w_cg;
    logic [WIDTH:0]      w_c;
    logic                w_unused_gmsb;

    assign w_s2_load = !r_s2_valid | bus.out_ready;
    assign w_s1_load = !r_s1_valid | w_s2_load;

    assign w_b_eff = bus.sub ? ~bus.b : bus.b;
    assign w_c0    = bus.sub ? 1'b1 : bus.cin;
    assign w_p     = bus.a ^ w_b_eff;
    assign w_g     = bus.a & w_b_eff;

    always_comb begin
        w_gp = '1;
        w_gg = '0;
        for (int k = 0; k < c_NGRP; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                w_gg[k] = w_g[k*GROUP+i] | (w_p[k*GROUP+i] & w_gg[k]);
                w_gp[k] = w_gp[k] & w_p[k*GROUP+i];
            end
        end
    end

    // Group carries as flat sum-of-products over the registered group P/G
    always_comb begin
        logic t;
        logic pp;
        t    = 1'b0;
        pp   = 1'b0;
        w_cg = '0;
        w_cg[0] = r_c0;
        for (int k = 0; k < c_NGRP; k++) begin
            t  = r_gg[k];
            pp = r_gp[k];
            for (int j = k - 1; j >= 0; j--) begin
                t  = t | (pp & r_gg[j]);
                pp = pp & r_gp[j];
            end
            w_cg[k+1] = t | (pp & r_c0);
        end
    end

    // In-group carries expanded from the group carry-in, no bit-to-bit ripple
    always_comb begin
        logic t;
        logic pp;
        t   = 1'b0;
        pp  = 1'b0;
        w_c = '0;
        for (int k = 0; k < c_NGRP; k++) begin
            w_c[k*GROUP] = w_cg[k];
            for (int i = 1; i < GROUP; i++) begin
                t  = r_g[k*GROUP+i-1];
                pp = r_p[k*GROUP+i-1];
                for (int j = i - 2; j >= 0; j--) begin
                    t  = t | (pp & r_g[k*GROUP+j]);
                    pp = pp & r_p[k*GROUP+j];
                end
                w_c[k*GROUP+i] = t | (pp & w_cg[k]);
            end
        end
        w_c[WIDTH] = w_cg[c_NGRP];
    end

    // Each group's MSB generate only contributes through its group G term
    always_comb begin
        w_unused_gmsb = 1'b0;
        for (int k = 0; k < c_NGRP; k++) begin
            w_unused_gmsb = w_unused_gmsb ^ r_g[k*GROUP+GROUP-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_gp       <= '0;
            r_gg       <= '0;
            r_c0       <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s        <= '0;
            r_cout     <= 1'b0;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_p  <= w_p;
                    r_g  <= w_g;
                    r_gp <= w_gp;
                    r_gg <= w_gg;
                    r_c0 <= w_c0;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s    <= r_p ^ w_c[WIDTH-1:0];
                    r_cout <= w_c[WIDTH];
`ifdef PIPELINED_CLA_ADDER_OVF_EN
                    r_ovf  <= w_c[WIDTH-1] ^ w_c[WIDTH];
`endif
                end
            end
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits; legal values are multiples of GROUP with WIDTH >= GROUP.
REQ-002 The block SHALL have parameter GROUP, default 4: bits per carry-lookahead group; legal values are 2 or 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input operation is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used for add only.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 selects a - b, 0 selects a + b + cin.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port s, output, WIDTH bits: the sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit: carry-out of the MSB; for subtract, 1 means no borrow.

Function
REQ-014 An operation SHALL be accepted on a rising clk edge when in_valid = 1 and in_ready = 1.
REQ-015 Subtract SHALL be computed as a + ~b + 1; when sub = 1, cin SHALL be ignored.
REQ-016 Stage 1 SHALL register per-bit p = a ^ b_eff and g = a & b_eff, group P/G for each GROUP-bit slice, and the effective carry-in.
REQ-017 Stage 2 SHALL compute group carries by lookahead across groups, then ripple-free in-group carries, s = p ^ c and cout; it SHALL register the results.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid = 1 when out_ready = 1 throughout.
REQ-019 Throughput SHALL be one operation per cycle with no bubbles while out_ready = 1.
REQ-020 Stage 2 SHALL load when it is empty or out_ready = 1.
REQ-021 Stage 1 SHALL load when it is empty or stage 2 loads.
REQ-022 in_ready SHALL equal (!s1_valid | s2_load), computed combinationally.
REQ-023 While out_valid = 1 and out_ready = 0, s, cout and out_valid SHALL hold stable.
REQ-024 Under backpressure, at most 2 operations SHALL be held; none SHALL be lost or reordered.
REQ-025 When a stage drains while no new input arrives, its valid SHALL clear on the same edge.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; the carry beyond the MSB SHALL appear only on cout.

Reset
REQ-027 Asserting rst SHALL immediately clear both stage valid bits, out_valid, s and cout to 0, with no clock required.
REQ-028 Reset mid-operation SHALL discard all in-flight operations.
REQ-029 in_ready SHALL be 1 on the first clk edge after rst deasserts.

Configuration
REQ-030 The macro PIPELINED_CLA_ADDER_OVF_EN, when defined, SHALL add output ovf (1 bit): signed two's-complement overflow, equal to c[WIDTH-1] ^ cout, registered and held with s.
REQ-031 When PIPELINED_CLA_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-032 WIDTH=16: a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, out_valid exactly 2 cycles after acceptance.
REQ-033 WIDTH=16: a=0x0005, b=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0 (cin ignored); with the macro defined, ovf=0.
REQ-034 Macro defined: a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, cout=0, ovf=1.
REQ-035 Send 3 back-to-back operations with out_ready=0 -> 2 accepted, then in_ready=0; raise out_ready -> results emerge in order, third accepted.
REQ-036 Assert rst asynchronously with both stages full -> out_valid=0, s=0, cout=0 before the next edge; no stale result after release.
REQ-037 WIDTH=8, GROUP=2: a=0xAA, b=0x55, cin=1 -> s=0x00, cout=1.
